organ_seq_ctrl: RTL and testbench

ORGAN_SEQ_CTRL -- requirements
Module: organ_seq_ctrl

---
 rtl/organ_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_organ_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/organ_seq_ctrl.sv
// Organ sequencer: records live keys into note memory and replays them.
// Define ORGAN_SEQ_LOOP_EN to loop playback instead of stopping at the end.
module organ_seq_ctrl #(
  parameter int MAX_NOTES = 64,
  parameter int ADDR_W    = 6,
  parameter int TEMPO_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic [2:0]        key_value,
  input  logic [1:0]        key_tone,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_value,
  output logic [1:0]        wr_tone,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_value,
  input  logic [1:0]        rd_tone,
  output logic [2:0]        note_value,
  output logic [1:0]        note_tone,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   note_count,
  output logic              full
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(MAX_NOTES);

  state_t state, state_n;

  // Button bits are ordered {stop, play, rec}
  logic [2:0] btn_s1, btn_s2, btn_q;
  logic [2:0] key_s1, key_s2;
  logic [1:0] tone_s1, tone_s2;
  logic       key_q;

  logic [TEMPO_W-1:0] tempo, tempo_n;
  logic               held, held_n;
  logic [ADDR_W:0]    cnt_n;
  logic               full_n;
  logic               wr_en_n;
  logic [ADDR_W-1:0]  wr_addr_n, rd_addr_n;
  logic [2:0]         wr_value_n, nv_n;
  logic [1:0]         wr_tone_n, nt_n;

  logic rec_e, play_e, stop_e;
  logic press, release_k;
  logic [ADDR_W:0] cnt_inc;
  logic at_max, last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_q   <= '0;
      key_s1  <= '0;
      key_s2  <= '0;
      tone_s1 <= '0;
      tone_s2 <= '0;
      key_q   <= 1'b0;
    end else begin
      btn_s1  <= {stop_btn, play_btn, rec_btn};
      btn_s2  <= btn_s1;
      btn_q   <= btn_s2;
      key_s1  <= key_value;
      key_s2  <= key_s1;
      tone_s1 <= key_tone;
      tone_s2 <= tone_s1;
      key_q   <= |key_s2;
    end
  end

  assign rec_e     = btn_s2[0] & ~btn_q[0];
  assign play_e    = btn_s2[1] & ~btn_q[1];
  assign stop_e    = btn_s2[2] & ~btn_q[2];
  assign press     = (|key_s2) & ~key_q;
  assign release_k = ~(|key_s2) & key_q;

  assign cnt_inc   = note_count + CNT_ONE;
  assign at_max    = (cnt_inc == CNT_MAX);
  assign last_step = ({1'b0, rd_addr} == note_count - CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      note_count <= '0;
      full       <= 1'b0;
      held       <= 1'b0;
      tempo      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_value   <= '0;
      wr_tone    <= '0;
      rd_addr    <= '0;
      note_value <= '0;
      note_tone  <= '0;
    end else begin
      state      <= state_n;
      note_count <= cnt_n;
      full       <= full_n;
      held       <= held_n;
      tempo      <= tempo_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_value   <= wr_value_n;
      wr_tone    <= wr_tone_n;
      rd_addr    <= rd_addr_n;
      note_value <= nv_n;
      note_tone  <= nt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = note_count;
    full_n     = full;
    held_n     = held;
    tempo_n    = '0;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_value_n = wr_value;
    wr_tone_n  = wr_tone;
    rd_addr_n  = rd_addr;
    nv_n       = key_s2;
    nt_n       = tone_s2;
    unique case (state)
      IDLE: begin
        if (stop_e) begin
          state_n = IDLE;
        end else if (rec_e) begin
          state_n = REC;
          cnt_n   = '0;
          full_n  = 1'b0;
          held_n  = 1'b0;
        end else if (play_e && note_count != '0) begin
          state_n   = PLAY;
          rd_addr_n = '0;
        end
      end
      REC: begin
        if (stop_e || play_e) begin
          state_n = IDLE;
          held_n  = 1'b0;
          if (held) begin
            cnt_n  = cnt_inc;
            full_n = at_max;
          end
        end else if (press && !full) begin
          wr_en_n    = 1'b1;
          wr_addr_n  = note_count[ADDR_W-1:0];
          wr_value_n = key_s2;
          wr_tone_n  = tone_s2;
          held_n     = 1'b1;
        end else if (release_k && held) begin
          cnt_n  = cnt_inc;
          held_n = 1'b0;
          if (at_max) begin
            full_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      PLAY: begin
        // rd data is stale the cycle after an address step; hold then
        nv_n = (tempo == '0) ? note_value : rd_value;
        nt_n = (tempo == '0) ? note_tone : rd_tone;
        if (stop_e) begin
          state_n   = IDLE;
          rd_addr_n = '0;
          nv_n      = '0;
          nt_n      = '0;
        end else if (rec_e) begin
          state_n   = REC;
          cnt_n     = '0;
          full_n    = 1'b0;
          held_n    = 1'b0;
          rd_addr_n = '0;
        end else begin
          tempo_n = tempo + TEMPO_W'(1);
          if (tempo == '1) begin
            if (last_step) begin
              rd_addr_n = '0;
`ifndef ORGAN_SEQ_LOOP_EN
              state_n = IDLE;
`endif
            end else begin
              rd_addr_n = rd_addr + ADDR_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mode = state;

endmodule

// File: tb/tb_organ_seq_ctrl.sv
// Bench for organ_seq_ctrl: directed flow with random note content,
// checked against a note-list model and a behavioural note memory.
module tb_organ_seq_ctrl;

  localparam int MN = 4;
  localparam int AW = 2;
  localparam int TW = 4;
  localparam int STEP = 1 << TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rec_btn = 1'b0, play_btn = 1'b0, stop_btn = 1'b0;
  logic [2:0]    key_value = '0;
  logic [1:0]    key_tone = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [2:0]    wr_value, rd_value, note_value;
  logic [1:0]    wr_tone, rd_tone, note_tone, mode;
  logic [AW:0]   note_count;
  logic          full;

  organ_seq_ctrl #(.MAX_NOTES(MN), .ADDR_W(AW), .TEMPO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .rec_btn(rec_btn), .play_btn(play_btn), .stop_btn(stop_btn),
    .key_value(key_value), .key_tone(key_tone),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_value(wr_value), .wr_tone(wr_tone),
    .rd_addr(rd_addr), .rd_value(rd_value), .rd_tone(rd_tone),
    .note_value(note_value), .note_tone(note_tone),
    .mode(mode), .note_count(note_count), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [2:0] mem_v [MN];
  logic [1:0] mem_t [MN];
  logic [6:0] got_wr [$];
  logic [6:0] exp_wr [$];
  logic [4:0] notes [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Note memory with one-cycle read latency
  always @(posedge clk) begin
    if (wr_en) begin
      mem_v[wr_addr] <= wr_value;
      mem_t[wr_addr] <= wr_tone;
    end
    rd_value <= mem_v[rd_addr];
    rd_tone  <= mem_t[rd_addr];
  end

  always @(posedge clk) begin
    if (wr_en) begin
      got_wr.push_back({wr_addr, wr_value, wr_tone});
      chk("wr_in_rec", 32'(mode), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn(input bit r, input bit p, input bit s);
    rec_btn = r; play_btn = p; stop_btn = s;
    cyc(3);
    rec_btn = 0; play_btn = 0; stop_btn = 0;
    cyc(4);
  endtask

  task automatic key_up();
    key_value = '0; key_tone = '0;
    cyc(5);
  endtask

  task automatic rec_note(input logic [2:0] v, input logic [1:0] t,
                          input bit up);
    logic [1:0] a;
    a = 2'(notes.size());
    notes.push_back({v, t});
    exp_wr.push_back({a, v, t});
    key_value = v; key_tone = t;
    cyc(5);
    chk("monitor", 32'({note_value, note_tone}), 32'({v, t}));
    if (up) key_up();
  endtask

  task automatic start_rec();
    notes.delete(); exp_wr.delete(); got_wr.delete();
    btn(1, 0, 0);
    chk("rec_mode", 32'(mode), 32'd1);
    chk("rec_cnt", 32'(note_count), 32'd0);
    chk("rec_full", 32'(full), 32'd0);
  endtask

  task automatic chk_wr(input string tag);
    chk({tag, "_n"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      chk(tag, 32'(got_wr[i]), 32'(exp_wr[i]));
  endtask

  // Random note that differs from the previous one (and from the first
  // one when it closes the sequence) so playback runs stay separable
  task automatic rand_note(input int k, input int n, input logic [4:0] prev,
                           output logic [2:0] v, output logic [1:0] t);
    bit again;
    do begin
      v = 3'($urandom_range(1, 7));
      t = 2'($urandom_range(0, 3));
      again = ({v, t} == prev);
      if (k == n - 1 && k > 0 && {v, t} == notes[0]) again = 1;
    end while (again);
  endtask

  task automatic enter_play(output bit ok);
    ok = 0;
    play_btn = 1;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = (mode == 2'b10);
    end
    play_btn = 0;
  endtask

  task automatic play_check(input string tag);
    int n, w;
    bit ok;
    logic [4:0] cur;
    logic [4:0] rv [$];
    int rl [$];
    n = notes.size();
    w = STEP * (n + 1) + 4;
    enter_play(ok);
    chk({tag, "_enter"}, 32'(ok), 32'd1);
    if (!ok) return;
    for (int i = 0; i < w; i++) begin
      cur = {note_value, note_tone};
      if (rv.size() != 0 && rv[rv.size()-1] == cur)
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      else begin
        rv.push_back(cur);
        rl.push_back(1);
      end
      if (i != w - 1) @(negedge clk);
    end
    chk({tag, "_runs"}, 32'(rv.size() >= n + 2), 32'd1);
    if (rv.size() < n + 2) return;
    chk({tag, "_lead"}, 32'(rv[0]), 32'd0);
    chk({tag, "_leadlen"}, 32'(rl[0]), 32'd2);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_note"}, 32'(rv[i+1]), 32'(notes[i]));
`ifdef ORGAN_SEQ_LOOP_EN
      chk({tag, "_len"}, 32'(rl[i+1]), 32'(STEP));
`else
      chk({tag, "_len"}, 32'(rl[i+1]), 32'((i == n - 1) ? STEP - 1 : STEP));
`endif
    end
`ifdef ORGAN_SEQ_LOOP_EN
    chk({tag, "_wrap"}, 32'(rv[n+1]), 32'(notes[0]));
    chk({tag, "_loopmode"}, 32'(mode), 32'd2);
    btn(0, 0, 1);
`else
    chk({tag, "_tail"}, 32'(rv[n+1]), 32'd0);
`endif
    chk({tag, "_endmode"}, 32'(mode), 32'd0);
    chk({tag, "_endaddr"}, 32'(rd_addr), 32'd0);
  endtask

  initial begin
    logic [2:0] v;
    logic [1:0] t;
    logic [4:0] prev;
    logic [AW:0] c;
    bit ok;
    for (int i = 0; i < MN; i++) begin
      mem_v[i] = '0;
      mem_t[i] = '0;
    end
    cyc(3);
    rst = 0;
    cyc(2);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_cnt", 32'(note_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wr", 32'({wr_en, wr_addr}), 32'd0);
    chk("rst_rd", 32'(rd_addr), 32'd0);
    chk("rst_note", 32'({note_value, note_tone}), 32'd0);

    btn(0, 1, 0);
    chk("empty_play_mode", 32'(mode), 32'd0);
    chk("empty_play_addr", 32'(rd_addr), 32'd0);

    start_rec();
    rec_note(3'd3, 2'd1, 1);
    rec_note(3'd5, 2'd2, 1);
    btn(0, 0, 1);
    chk_wr("wr_basic");
    chk("basic_cnt", 32'(note_count), 32'd2);
    chk("basic_mode", 32'(mode), 32'd0);
    play_check("play_basic");

    for (int it = 0; it < 3; it++) begin
      int n;
      bit hold, via_play;
      n = $urandom_range(2, 3);
      hold = 1'($urandom_range(0, 1));
      via_play = 1'($urandom_range(0, 1));
      start_rec();
      prev = '0;
      for (int k = 0; k < n; k++) begin
        rand_note(k, n, prev, v, t);
        rec_note(v, t, !(hold && k == n - 1));
        prev = {v, t};
      end
      btn(0, via_play, !via_play);
      if (hold) key_up();
      chk_wr("wr_rand");
      chk("rand_cnt", 32'(note_count), 32'(n));
      chk("rand_mode", 32'(mode), 32'd0);
      play_check("play_rand");
    end

    c = note_count;
    btn(1, 0, 1);
    chk("recstop_mode", 32'(mode), 32'd0);
    chk("recstop_cnt", 32'(note_count), 32'(c));
    start_rec();
    rec_note(3'd6, 2'd3, 1);
    btn(0, 1, 1);
    chk("stopplay_mode", 32'(mode), 32'd0);
    chk("stopplay_cnt", 32'(note_count), 32'd1);
    chk_wr("wr_stopplay");

    start_rec();
    prev = '0;
    for (int k = 0; k < MN; k++) begin
      rand_note(k, MN, prev, v, t);
      rec_note(v, t, 1);
      prev = {v, t};
      if (k == MN - 2) begin
        chk("prefull_full", 32'(full), 32'd0);
        chk("prefull_mode", 32'(mode), 32'd1);
      end
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_mode", 32'(mode), 32'd0);
    chk("full_cnt", 32'(note_count), 32'(MN));
    key_value = 3'd7; key_tone = 2'd0;
    cyc(5);
    chk("full_nowr", 32'(got_wr.size()), 32'(MN));
    key_up();
    chk_wr("wr_full");
    play_check("play_full");

    key_value = 3'd7; key_tone = 2'd3;
    enter_play(ok);
    chk("stop_enter", 32'(ok), 32'd1);
    cyc(20);
    chk("play_ignore_live", 32'({note_value, note_tone}), 32'(notes[1]));
    stop_btn = 1;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = (mode == 2'b00);
    end
    chk("stop_seen", 32'(ok), 32'd1);
    chk("stop_note0", 32'({note_value, note_tone}), 32'd0);
    @(negedge clk);
    chk("stop_live", 32'({note_value, note_tone}), 32'({3'd7, 2'd3}));
    chk("stop_addr", 32'(rd_addr), 32'd0);
    stop_btn = 0;
    key_up();

    enter_play(ok);
    chk("prec_enter", 32'(ok), 32'd1);
    cyc(5);
    btn(1, 0, 0);
    chk("prec_mode", 32'(mode), 32'd1);
    chk("prec_cnt", 32'(note_count), 32'd0);
    btn(0, 0, 1);

    start_rec();
    rec_note(3'd2, 2'd0, 1);
    rec_note(3'd4, 2'd1, 1);
    btn(0, 0, 1);
    enter_play(ok);
    chk("rst_enter", 32'(ok), 32'd1);
    cyc(10);
    #2 rst = 1;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_cnt", 32'(note_count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_wr", 32'({wr_en, wr_addr, wr_value, wr_tone}), 32'd0);
    chk("arst_rd", 32'(rd_addr), 32'd0);
    chk("arst_note", 32'({note_value, note_tone}), 32'd0);
    cyc(2);
    rst = 0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
